// File: rtl/wb_lcd_ctrl_if.sv
// Wishbone slave-side bus bundle for the character-LCD controller.
// The controller uses the slave modport; the bus master (CPU or bench) uses master.
interface wb_lcd_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_lcd_ctrl.sv
// Wishbone slave that queues HD44780 command/data bytes and replays them on the
// LCD pins with programmable setup / enable-pulse / hold / execution timing.
module wb_lcd_ctrl #(
  parameter int BUS_WIDTH     = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int SETUP_CYC     = 4,
  parameter int E_HIGH_CYC    = 24,
  parameter int HOLD_CYC      = 4,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_lcd_if.slave              bus,
  output logic                 E,
  output logic                 RS,
  output logic [BUS_WIDTH-1:0] Data_out
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max_of(max_of(max_of(SETUP_CYC, E_HIGH_CYC), max_of(HOLD_CYC, EXEC_CYC)),
                                  LONG_EXEC_CYC);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit NIBBLE_MODE = (BUS_WIDTH == 4);

  // A phase of N cycles loads N-1 and ends when the counter reads zero.
  function automatic logic [CW-1:0] load_of(input int cyc);
    return (cyc > 0) ? CW'(cyc - 1) : '0;
  endfunction

  localparam logic [CW-1:0] SETUP_LD  = load_of(SETUP_CYC);
  localparam logic [CW-1:0] E_HIGH_LD = load_of(E_HIGH_CYC);
  localparam logic [CW-1:0] HOLD_LD   = load_of(HOLD_CYC);
  localparam logic [CW-1:0] EXEC_LD   = load_of(EXEC_CYC);
  localparam logic [CW-1:0] LONG_LD   = load_of(LONG_EXEC_CYC);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   e_reg, e_next;
  logic                   rs_reg, rs_next;
  logic [BUS_WIDTH-1:0]   data_reg, data_next;
  logic [7:0]             cur_reg, cur_next;
  logic                   nib_reg, nib_next;

  logic [8:0]             fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]            count_reg;
  logic                   ack_reg, ovf_reg;
  logic [31:0]            dat_o_reg;

  logic                   access, push, push_ok, pop, clr_ovf, empty, full, busy;
  logic [8:0]             push_entry, head_entry;
  logic [BUS_WIDTH-1:0]   first_beat, second_beat;
  logic [CW-1:0]          exec_ld;
  logic [31:0]            status;
  logic                   unused_bits;

  assign unused_bits = ^{bus.wb_sel_i, bus.wb_adr_i[31:4], bus.wb_dat_i[31:8]};

  // Side effects fire only on the cycle that raises ack, so a held strobe cannot double-push.
  assign access     = bus.wb_stb_i & bus.wb_cyc_i & ~ack_reg;
  assign push       = access & bus.wb_we_i & ((bus.wb_adr_i[3:0] == 4'h0) | (bus.wb_adr_i[3:0] == 4'h4));
  assign clr_ovf    = access & bus.wb_we_i & (bus.wb_adr_i[3:0] == 4'h8) & bus.wb_dat_i[3];
  assign push_entry = {(bus.wb_adr_i[3:0] == 4'h0), bus.wb_dat_i[7:0]};
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign push_ok    = push & (~full | pop);
  assign busy       = (state_reg != S_IDLE) | ~empty;
  assign status     = {16'h0, 8'(count_reg), 4'h0, ovf_reg, empty, full, busy};

  // Small FIFO read asynchronously so the pop cycle can already present RS/data;
  // an empty FIFO forwards a same-cycle push straight to the FSM.
  assign head_entry = empty ? push_entry : fifo_mem[rd_ptr_reg];

  generate
    if (NIBBLE_MODE) begin : g_nibble
      assign first_beat  = head_entry[7:4];
      assign second_beat = cur_reg[3:0];
    end else begin : g_byte
      assign first_beat  = head_entry[7:0];
      assign second_beat = cur_reg[BUS_WIDTH-1:0];
    end
  endgenerate

  assign exec_ld = (~rs_reg && ((cur_reg == 8'h01) || (cur_reg == 8'h02))) ? LONG_LD : EXEC_LD;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    e_next     = e_reg;
    rs_next    = rs_reg;
    data_next  = data_reg;
    cur_next   = cur_reg;
    nib_next   = nib_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (~empty | push) begin
          pop        = 1'b1;
          rs_next    = head_entry[8];
          cur_next   = head_entry[7:0];
          data_next  = first_beat;
          nib_next   = 1'b0;
          cnt_next   = SETUP_LD;
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_reg == '0) begin
          e_next     = 1'b1;
          cnt_next   = E_HIGH_LD;
          state_next = S_PULSE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_reg == '0) begin
          e_next     = 1'b0;
          cnt_next   = HOLD_LD;
          state_next = S_HOLD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (NIBBLE_MODE && ~nib_reg) begin
          nib_next   = 1'b1;
          data_next  = second_beat;
          cnt_next   = SETUP_LD;
          state_next = S_SETUP;
        end else begin
          cnt_next   = exec_ld;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_reg == '0) state_next = S_IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      e_reg     <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= '0;
      cur_reg   <= '0;
      nib_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      e_reg     <= e_next;
      rs_reg    <= rs_next;
      data_reg  <= data_next;
      cur_reg   <= cur_next;
      nib_reg   <= nib_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ack_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      dat_o_reg  <= '0;
    end else begin
      ack_reg <= access;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok & ~pop)      count_reg <= count_reg + 1'b1;
      else if (~push_ok & pop) count_reg <= count_reg - 1'b1;
      if (clr_ovf)                ovf_reg <= 1'b0;
      else if (push & ~push_ok)   ovf_reg <= 1'b1;
      if (access) dat_o_reg <= (~bus.wb_we_i && (bus.wb_adr_i[3:0] == 4'h8)) ? status : 32'h0;
    end
  end

  assign bus.wb_ack_o = bus.wb_stb_i & bus.wb_cyc_i & ack_reg;
  assign bus.wb_dat_o = dat_o_reg;
  assign E            = e_reg;
  assign RS           = rs_reg;
  assign Data_out     = data_reg;

endmodule

// File: tb/tb_wb_lcd_ctrl.sv
// Bench for wb_lcd_ctrl: an 8-bit and a 4-bit instance share one bus stimulus and
// are checked every cycle against a queue/timeline model plus literal expectations.
module tb_wb_lcd_ctrl;
  localparam int S = 3, EH = 5, H = 2, EX = 20, LX = 300, DEPTH = 16;

  logic clk = 1'b0, reset = 1'b1;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic e8, rs8, e4, rs4;
  logic [7:0] d8;
  logic [3:0] d4;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  wb_lcd_if bus8 ();
  wb_lcd_if bus4 ();
  assign bus8.wb_stb_i = stb;  assign bus4.wb_stb_i = stb;
  assign bus8.wb_cyc_i = cyc;  assign bus4.wb_cyc_i = cyc;
  assign bus8.wb_we_i  = we;   assign bus4.wb_we_i  = we;
  assign bus8.wb_adr_i = adr;  assign bus4.wb_adr_i = adr;
  assign bus8.wb_sel_i = 4'hF; assign bus4.wb_sel_i = 4'hF;
  assign bus8.wb_dat_i = dat;  assign bus4.wb_dat_i = dat;

  wb_lcd_ctrl #(.BUS_WIDTH(8), .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(H),
                .EXEC_CYC(EX), .LONG_EXEC_CYC(LX))
    dut8 (.clk(clk), .reset(reset), .bus(bus8), .E(e8), .RS(rs8), .Data_out(d8));
  wb_lcd_ctrl #(.BUS_WIDTH(4), .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(H),
                .EXEC_CYC(EX), .LONG_EXEC_CYC(LX))
    dut4 (.clk(clk), .reset(reset), .bus(bus4), .E(e4), .RS(rs4), .Data_out(d4));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: each DUT is a queue of accepted bytes plus "cycles since pop" of the byte in flight.
  logic [8:0]  mq [2][$];
  bit          act [2];
  int          t_m [2];
  int          blen [2];
  logic [8:0]  cur [2];
  bit          ovf [2];
  logic [31:0] exp_dat [2];
  bit          ack_m;

  initial begin
    bit acc, push, clr, popn;
    logic [8:0] pe;
    logic [31:0] st;
    forever begin
      @(posedge clk);
      if (reset) begin
        ack_m = 1'b0;
        for (int d = 0; d < 2; d++) begin
          mq[d].delete(); act[d] = 1'b0; t_m[d] = 0; cur[d] = '0; ovf[d] = 1'b0; exp_dat[d] = '0;
        end
      end else begin
        acc  = stb && cyc && !ack_m;
        push = acc && we && (adr[3:0] == 4'h0 || adr[3:0] == 4'h4);
        clr  = acc && we && adr[3:0] == 4'h8 && dat[3];
        pe   = {adr[3:0] == 4'h0, dat[7:0]};
        for (int d = 0; d < 2; d++) begin
          st = {16'h0, 8'(mq[d].size()), 4'h0, ovf[d], mq[d].size() == 0, mq[d].size() == DEPTH,
                act[d] || mq[d].size() > 0};
          if (acc) exp_dat[d] = (!we && adr[3:0] == 4'h8) ? st : 32'h0;
          popn = !act[d] && (mq[d].size() > 0 || push);
          if (push) begin
            if (mq[d].size() < DEPTH || popn) mq[d].push_back(pe);
            else ovf[d] = 1'b1;
          end
          if (clr) ovf[d] = 1'b0;
          if (act[d]) begin
            t_m[d]++;
            if (t_m[d] == blen[d]) act[d] = 1'b0;
          end
          if (popn) begin
            cur[d] = mq[d].pop_front();
            act[d] = 1'b1;
            t_m[d] = 0;
            blen[d] = ((d == 0) ? (S + EH + H) : 2 * (S + EH + H)) +
                      ((!cur[d][8] && (cur[d][7:0] == 8'h01 || cur[d][7:0] == 8'h02)) ? LX : EX);
          end
        end
        ack_m = acc;
      end
    end
  end

  // Per-cycle compare plus an E-edge log used by the literal checks.
  int ncyc = 0;
  int rise_c [2][$];
  int fall_c [2][$];
  logic [7:0] rise_d [2][$];
  logic rise_rs [2][$];
  string nm [2] = '{"dut8", "dut4"};

  initial begin
    logic exp_e, exp_rs, got_e, got_rs;
    logic [7:0] exp_dv, got_dv;
    logic prev_e [2];
    logic [31:0] got_ack, got_dat;
    int tt;
    prev_e[0] = 1'b0; prev_e[1] = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      for (int d = 0; d < 2; d++) begin
        got_e   = (d == 0) ? e8 : e4;
        got_rs  = (d == 0) ? rs8 : rs4;
        got_dv  = (d == 0) ? d8 : {4'h0, d4};
        got_ack = {31'h0, (d == 0) ? bus8.wb_ack_o : bus4.wb_ack_o};
        got_dat = (d == 0) ? bus8.wb_dat_o : bus4.wb_dat_o;
        if (got_e && !prev_e[d]) begin
          rise_c[d].push_back(ncyc); rise_d[d].push_back(got_dv); rise_rs[d].push_back(got_rs);
        end
        if (!got_e && prev_e[d]) fall_c[d].push_back(ncyc);
        prev_e[d] = got_e;
        if (!reset) begin
          exp_rs = cur[d][8];
          exp_e  = 1'b0;
          if (act[d]) begin
            tt = t_m[d];
            if (d == 0) exp_dv = cur[d][7:0];
            else if (tt >= S + EH + H) begin
              tt = tt - (S + EH + H);
              exp_dv = {4'h0, cur[d][3:0]};
            end else exp_dv = {4'h0, cur[d][7:4]};
            exp_e = (tt >= S) && (tt < S + EH);
          end else begin
            exp_dv = (d == 0) ? cur[d][7:0] : {4'h0, cur[d][3:0]};
          end
          check({nm[d], "_E"}, {31'h0, got_e}, {31'h0, exp_e});
          check({nm[d], "_RS"}, {31'h0, got_rs}, {31'h0, exp_rs});
          check({nm[d], "_Data"}, {24'h0, got_dv}, {24'h0, exp_dv});
          check({nm[d], "_ack"}, got_ack, {31'h0, stb && cyc && ack_m});
          if (ack_m && stb && cyc && !we) check({nm[d], "_rdata"}, got_dat, exp_dat[d]);
        end
      end
    end
  end

  // Called #1 after a posedge; the next posedge is the access edge, ack is high in the following cycle.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] v, input bit hold,
                         output logic [31:0] r8, output logic [31:0] r4);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = v;
    @(posedge clk); #1;
    r8 = bus8.wb_dat_o; r4 = bus4.wb_dat_o;
    $display("[TB] %s adr=0x%0h dat=0x%02h rd8=0x%08h rd4=0x%08h", w ? "WR" : "RD", a, v[7:0], r8, r4);
    @(posedge clk); #1;
    if (!hold) begin stb = 1'b0; cyc = 1'b0; we = 1'b0; end
  endtask

  initial begin
    logic [31:0] r8, r4;
    int r0 [2], f0 [2];
    bit seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset in the middle of an E pulse
    wb_xfer(1, 32'h0, 32'h5A, 0, r8, r4);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (e8 === 1'b1);
    end
    check("t1_e_high_before_reset", {31'h0, e8}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t1_reset_E8", {31'h0, e8}, 32'h0);
    check("t1_reset_RS8", {31'h0, rs8}, 32'h0);
    check("t1_reset_D8", {24'h0, d8}, 32'h0);
    check("t1_reset_E4", {31'h0, e4}, 32'h0);
    check("t1_reset_D4", {28'h0, d4}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wb_xfer(0, 32'h8, 32'h0, 0, r8, r4);
    check("t1_status8", r8, 32'h4);
    check("t1_status4", r4, 32'h4);

    // CMD 0x38: one (8-bit) / two (4-bit) pulses of EH cycles
    for (int d = 0; d < 2; d++) begin r0[d] = rise_c[d].size(); f0[d] = fall_c[d].size(); end
    wb_xfer(1, 32'h4, 32'h38, 0, r8, r4);
    repeat (50) @(posedge clk); #1;
    check("t2_rises8", rise_c[0].size() - r0[0], 1);
    check("t2_rises4", rise_c[1].size() - r0[1], 2);
    check("t2_width8", fall_c[0][f0[0]] - rise_c[0][r0[0]], EH);
    check("t2_data8", {24'h0, rise_d[0][r0[0]]}, 32'h38);
    check("t2_rs8", {31'h0, rise_rs[0][r0[0]]}, 32'h0);
    check("t2_nib_hi4", {24'h0, rise_d[1][r0[1]]}, 32'h3);
    check("t2_nib_lo4", {24'h0, rise_d[1][r0[1]+1]}, 32'h8);

    // DATA 0x41 in nibble mode
    for (int d = 0; d < 2; d++) r0[d] = rise_c[d].size();
    wb_xfer(1, 32'h0, 32'h41, 0, r8, r4);
    repeat (50) @(posedge clk); #1;
    check("t3_nib_hi4", {24'h0, rise_d[1][r0[1]]}, 32'h4);
    check("t3_nib_lo4", {24'h0, rise_d[1][r0[1]+1]}, 32'h1);
    check("t3_rs4", {31'h0, rise_rs[1][r0[1]+1]}, 32'h1);
    check("t3_nib_spacing4", rise_c[1][r0[1]+1] - rise_c[1][r0[1]], EH + H + S);
    check("t3_data8", {24'h0, rise_d[0][r0[0]]}, 32'h41);

    // Clear display followed by data: long exec gap
    for (int d = 0; d < 2; d++) begin r0[d] = rise_c[d].size(); f0[d] = fall_c[d].size(); end
    wb_xfer(1, 32'h4, 32'h01, 0, r8, r4);
    wb_xfer(1, 32'h0, 32'h55, 0, r8, r4);
    repeat (700) @(posedge clk); #1;
    check("t4_gap8", rise_c[0][r0[0]+1] - fall_c[0][f0[0]], H + LX + 1 + S);
    check("t4_gap4", rise_c[1][r0[1]+2] - fall_c[1][f0[1]+1], H + LX + 1 + S);

    // Overflow while stalled in a long exec, using back-to-back held-strobe writes
    for (int d = 0; d < 2; d++) r0[d] = rise_c[d].size();
    wb_xfer(1, 32'h4, 32'h01, 0, r8, r4);
    repeat (30) @(posedge clk); #1;
    for (int i = 0; i < 17; i++) wb_xfer(1, 32'h0, 32'h60 + i, i < 16, r8, r4);
    wb_xfer(0, 32'h8, 32'h0, 0, r8, r4);
    check("t5_status_full8", r8, 32'h0000_100B);
    check("t5_status_full4", r4, 32'h0000_100B);
    wb_xfer(1, 32'h8, 32'h8, 0, r8, r4);
    wb_xfer(0, 32'h8, 32'h0, 0, r8, r4);
    check("t5_ovf_clr8", r8, 32'h0000_1003);
    check("t5_ovf_clr4", r4, 32'h0000_1003);
    repeat (1000) @(posedge clk); #1;
    check("t5_rises8", rise_c[0].size() - r0[0], 17);
    check("t5_rises4", rise_c[1].size() - r0[1], 34);
    check("t5_last8", {24'h0, rise_d[0][rise_d[0].size()-1]}, 32'h6F);
    check("t5_last4", {24'h0, rise_d[1][rise_d[1].size()-1]}, 32'hF);

    // Push coinciding with the pop of a single queued entry (8-bit instance)
    wb_xfer(1, 32'h0, 32'hA1, 0, r8, r4);
    wb_xfer(1, 32'h0, 32'hB2, 0, r8, r4);
    repeat (27) @(posedge clk); #1;
    wb_xfer(1, 32'h0, 32'hC3, 0, r8, r4);
    wb_xfer(0, 32'h8, 32'h0, 0, r8, r4);
    check("t6_status8", r8, 32'h0000_0101);
    check("t6_status4", r4, 32'h0000_0201);
    repeat (200) @(posedge clk); #1;
    wb_xfer(0, 32'h8, 32'h0, 0, r8, r4);
    check("t6_idle8", r8, 32'h4);
    check("t6_idle4", r4, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
